// File: rtl/ts3d_stream_checker.sv
`default_nettype none
// ============================================================================
// Module      : ts3d_stream_checker
// Description : Golden-stream checker for TS3D bring-up. Compares NUM_CH DUT
//               sample streams against a tagged reference stream that is
//               buffered in one REF_DEPTH-entry FIFO per channel. Counts
//               compares and errors, captures the first error and can halt
//               on the first error.
// Ports       : clk/rst_n        clock, synchronous active-low reset
//               Cfg_*            control pulses and run configuration
//               Ref_Val/Rdy/Ch/Dat  reference word input (valid/ready)
//               Dut_Val/Dut_Dat  per-channel DUT samples
//               Chk_*            state, counters and first-error capture
// Revision    : 1.0 - initial release
// ============================================================================
module ts3d_stream_checker #(
    parameter int DATA_WIDTH = 324,
    parameter int NUM_CH     = 4,
    parameter int REF_DEPTH  = 16,
    parameter int CNT_WIDTH  = 16,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         Cfg_Start,
    input  logic                         Cfg_Flush,
    input  logic                         Cfg_StopOnErr,
    input  logic [CNT_WIDTH-1:0]         Cfg_Len,
    input  logic [DATA_WIDTH-1:0]        Cfg_Mask,
    input  logic                         Ref_Val,
    output logic                         Ref_Rdy,
    input  logic [CH_W-1:0]              Ref_Ch,
    input  logic [DATA_WIDTH-1:0]        Ref_Dat,
    input  logic [NUM_CH-1:0]            Dut_Val,
    input  logic [NUM_CH*DATA_WIDTH-1:0] Dut_Dat,
    output logic [1:0]                   Chk_State,
    output logic [CNT_WIDTH-1:0]         Chk_CntCmp,
    output logic [CNT_WIDTH-1:0]         Chk_CntErr,
    output logic                         Chk_ErrVld,
    output logic                         Chk_ErrUnd,
    output logic [CH_W-1:0]              Chk_ErrCh,
    output logic [CNT_WIDTH-1:0]         Chk_ErrIdx,
    output logic [DATA_WIDTH-1:0]        Chk_ErrDat
);

    localparam int PTR_W = $clog2(REF_DEPTH);
    localparam int NC_W  = $clog2(NUM_CH + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Control / capture registers
    logic [1:0]            state_q,   state_d;
    logic [CNT_WIDTH-1:0]  cnt_cmp_q, cnt_cmp_d;
    logic [CNT_WIDTH-1:0]  cnt_err_q, cnt_err_d;
    logic                  err_vld_q, err_vld_d;
    logic                  err_und_q, err_und_d;
    logic [CH_W-1:0]       err_ch_q,  err_ch_d;
    logic [CNT_WIDTH-1:0]  err_idx_q, err_idx_d;
    logic [DATA_WIDTH-1:0] err_dat_q, err_dat_d;
    logic                  stop_q;
    logic [CNT_WIDTH-1:0]  len_q;
    logic                  rdy_en_q;   // holds Ref_Rdy low while in reset

    // Per-channel FIFO status and head words
    logic [NUM_CH-1:0]            full_w;
    logic [NUM_CH-1:0]            empty_w;
    logic [NUM_CH-1:0]            push_w;
    logic [NUM_CH-1:0]            pop_w;
    logic [NUM_CH*DATA_WIDTH-1:0] head_w;

    // Samples are compared only in RUN and never in a Cfg_Start cycle
    logic cmp_en_w;
    assign cmp_en_w = (state_q == ST_RUN) && !Cfg_Start;

    logic ch_ok_w;
    assign ch_ok_w = ({1'b0, Ref_Ch} < (CH_W + 1)'(NUM_CH));
    assign Ref_Rdy = rdy_en_q && ch_ok_w && !full_w[Ref_Ch];

    genvar c;
    generate
        for (c = 0; c < NUM_CH; c++) begin : g_ch
            logic [DATA_WIDTH-1:0] mem_q [REF_DEPTH];
            logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
            logic [PTR_W:0]        occ_q;

            assign push_w[c]  = Ref_Val && Ref_Rdy && (Ref_Ch == CH_W'(c)) && !Cfg_Flush;
            assign pop_w[c]   = cmp_en_w && Dut_Val[c] && !empty_w[c];
            assign full_w[c]  = (occ_q == (PTR_W + 1)'(REF_DEPTH));
            assign empty_w[c] = (occ_q == '0);
            assign head_w[c*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_ptr_q];

            always_ff @(posedge clk) begin
                if (!rst_n || Cfg_Flush) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    occ_q    <= '0;
                end else begin
                    if (push_w[c]) wr_ptr_q <= wr_ptr_q + 1'b1;
                    if (pop_w[c])  rd_ptr_q <= rd_ptr_q + 1'b1;
                    case ({push_w[c], pop_w[c]})
                        2'b10:   occ_q <= occ_q + 1'b1;
                        2'b01:   occ_q <= occ_q - 1'b1;
                        default: occ_q <= occ_q;
                    endcase
                end
            end

            // Storage needs no reset: occupancy gates every read
            always_ff @(posedge clk) begin
                if (push_w[c]) mem_q[wr_ptr_q] <= Ref_Dat;
            end
        end
    endgenerate

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [NC_W-1:0]      b);
        logic [CNT_WIDTH:0] s;
        s = {1'b0, a} + (CNT_WIDTH + 1)'(b);
        return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
    endfunction

    logic [NC_W-1:0]       n_val_w, n_err_w;
    logic                  err_any_w, err_und_w;
    logic [CH_W-1:0]       err_ch_w;
    logic [DATA_WIDTH-1:0] err_dat_w;

    // Channels are scanned from high to low so the lowest erroring one wins
    always_comb begin
        n_val_w   = '0;
        n_err_w   = '0;
        err_any_w = 1'b0;
        err_und_w = 1'b0;
        err_ch_w  = '0;
        err_dat_w = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (cmp_en_w && Dut_Val[i]) begin
                n_val_w = n_val_w + NC_W'(1);
                if (empty_w[i] ||
                    (((Dut_Dat[i*DATA_WIDTH +: DATA_WIDTH] ^ head_w[i*DATA_WIDTH +: DATA_WIDTH])
                      & Cfg_Mask) != '0)) begin
                    n_err_w   = n_err_w + NC_W'(1);
                    err_any_w = 1'b1;
                    err_und_w = empty_w[i];
                    err_ch_w  = CH_W'(i);
                    err_dat_w = Dut_Dat[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_cmp_d = cnt_cmp_q;
        cnt_err_d = cnt_err_q;
        err_vld_d = err_vld_q;
        err_und_d = err_und_q;
        err_ch_d  = err_ch_q;
        err_idx_d = err_idx_q;
        err_dat_d = err_dat_q;
        if (Cfg_Start) begin
            state_d   = ST_RUN;
            cnt_cmp_d = '0;
            cnt_err_d = '0;
            err_vld_d = 1'b0;
            err_und_d = 1'b0;
            err_ch_d  = '0;
            err_idx_d = '0;
            err_dat_d = '0;
        end else if (state_q == ST_RUN) begin
            cnt_cmp_d = sat_add(cnt_cmp_q, n_val_w);
            cnt_err_d = sat_add(cnt_err_q, n_err_w);
            if (err_any_w && !err_vld_q) begin
                err_vld_d = 1'b1;
                err_und_d = err_und_w;
                err_ch_d  = err_ch_w;
                err_idx_d = cnt_cmp_q;
                err_dat_d = err_dat_w;
            end
            // Halt takes precedence over completion in the same cycle
            if (err_any_w && stop_q)
                state_d = ST_HALT;
            else if ((len_q != '0) && (cnt_cmp_d >= len_q))
                state_d = ST_DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_cmp_q <= '0;
            cnt_err_q <= '0;
            err_vld_q <= 1'b0;
            err_und_q <= 1'b0;
            err_ch_q  <= '0;
            err_idx_q <= '0;
            err_dat_q <= '0;
            stop_q    <= 1'b0;
            len_q     <= '0;
            rdy_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_cmp_q <= cnt_cmp_d;
            cnt_err_q <= cnt_err_d;
            err_vld_q <= err_vld_d;
            err_und_q <= err_und_d;
            err_ch_q  <= err_ch_d;
            err_idx_q <= err_idx_d;
            err_dat_q <= err_dat_d;
            rdy_en_q  <= 1'b1;
            if (Cfg_Start) begin
                stop_q <= Cfg_StopOnErr;
                len_q  <= Cfg_Len;
            end
        end
    end

    assign Chk_State  = state_q;
    assign Chk_CntCmp = cnt_cmp_q;
    assign Chk_CntErr = cnt_err_q;
    assign Chk_ErrVld = err_vld_q;
    assign Chk_ErrUnd = err_und_q;
    assign Chk_ErrCh  = err_ch_q;
    assign Chk_ErrIdx = err_idx_q;
    assign Chk_ErrDat = err_dat_q;

endmodule
`default_nettype wire

// File: tb/tb_ts3d_stream_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_ts3d_stream_checker
// Description : Directed, table-driven bench for ts3d_stream_checker. A
//               full-width instance covers the functional cases; a narrow
//               instance with 4-bit counters covers counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ts3d_stream_checker;

    localparam int DW = 324;
    localparam int NC = 4;
    localparam int RD = 16;
    localparam int CW = 16;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          Cfg_Start, Cfg_Flush, Cfg_StopOnErr;
    logic [CW-1:0] Cfg_Len;
    logic [DW-1:0] Cfg_Mask;
    logic          Ref_Val, Ref_Rdy;
    logic [1:0]    Ref_Ch;
    logic [DW-1:0] Ref_Dat;
    logic [NC-1:0] Dut_Val;
    logic [NC*DW-1:0] Dut_Dat;
    logic [1:0]    Chk_State;
    logic [CW-1:0] Chk_CntCmp, Chk_CntErr, Chk_ErrIdx;
    logic          Chk_ErrVld, Chk_ErrUnd;
    logic [1:0]    Chk_ErrCh;
    logic [DW-1:0] Chk_ErrDat;

    ts3d_stream_checker #(.DATA_WIDTH(DW), .NUM_CH(NC), .REF_DEPTH(RD), .CNT_WIDTH(CW)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .Cfg_Start(Cfg_Start), .Cfg_Flush(Cfg_Flush), .Cfg_StopOnErr(Cfg_StopOnErr),
        .Cfg_Len(Cfg_Len), .Cfg_Mask(Cfg_Mask),
        .Ref_Val(Ref_Val), .Ref_Rdy(Ref_Rdy), .Ref_Ch(Ref_Ch), .Ref_Dat(Ref_Dat),
        .Dut_Val(Dut_Val), .Dut_Dat(Dut_Dat),
        .Chk_State(Chk_State), .Chk_CntCmp(Chk_CntCmp), .Chk_CntErr(Chk_CntErr),
        .Chk_ErrVld(Chk_ErrVld), .Chk_ErrUnd(Chk_ErrUnd), .Chk_ErrCh(Chk_ErrCh),
        .Chk_ErrIdx(Chk_ErrIdx), .Chk_ErrDat(Chk_ErrDat)
    );

    // Narrow instance: 8-bit data, 4-bit counters
    logic          s_start, s_ref_val, s_ref_rdy, s_err_vld, s_err_und;
    logic [3:0]    s_len, s_cmp, s_err, s_err_idx;
    logic [7:0]    s_mask, s_ref_dat, s_err_dat;
    logic [1:0]    s_ref_ch, s_state, s_err_ch;
    logic [NC-1:0] s_dut_val;
    logic [NC*8-1:0] s_dut_dat;

    ts3d_stream_checker #(.DATA_WIDTH(8), .NUM_CH(NC), .REF_DEPTH(RD), .CNT_WIDTH(4)) u_small (
        .clk(clk), .rst_n(rst_n),
        .Cfg_Start(s_start), .Cfg_Flush(1'b0), .Cfg_StopOnErr(1'b0),
        .Cfg_Len(s_len), .Cfg_Mask(s_mask),
        .Ref_Val(s_ref_val), .Ref_Rdy(s_ref_rdy), .Ref_Ch(s_ref_ch), .Ref_Dat(s_ref_dat),
        .Dut_Val(s_dut_val), .Dut_Dat(s_dut_dat),
        .Chk_State(s_state), .Chk_CntCmp(s_cmp), .Chk_CntErr(s_err),
        .Chk_ErrVld(s_err_vld), .Chk_ErrUnd(s_err_und), .Chk_ErrCh(s_err_ch),
        .Chk_ErrIdx(s_err_idx), .Chk_ErrDat(s_err_dat)
    );

    typedef struct {
        logic [NC-1:0] val;
        logic [NC-1:0] flip;    // channels whose sample has bit 7 inverted
        int            cmp;
        int            err;
        logic [1:0]    st;
    } vec_t;

    vec_t tbl[18];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   wr_k[NC];
    int   rd_k[NC];
    logic [1:0] cur_st;
    logic [DW-1:0] bit7;

    function automatic logic [DW-1:0] mkw(input int c, input int k);
        logic [DW-1:0] w;
        w = '0;
        for (int i = 0; i < 10; i++) w[i*32 +: 32] = 32'h9E3779B9 * (c * 64 + k + 1) + i;
        w[323:320] = 4'(k);
        return w;
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int c);
        Ref_Val = 1'b1;
        Ref_Ch  = 2'(c);
        Ref_Dat = mkw(c, wr_k[c]);
        step();
        Ref_Val = 1'b0;
        wr_k[c]++;
    endtask

    task automatic flush();
        Cfg_Flush = 1'b1;
        step();
        Cfg_Flush = 1'b0;
        for (int c = 0; c < NC; c++) begin
            wr_k[c] = 0;
            rd_k[c] = 0;
        end
    endtask

    task automatic start(input int len, input logic stop);
        Cfg_Start     = 1'b1;
        Cfg_Len       = CW'(len);
        Cfg_StopOnErr = stop;
        step();
        Cfg_Start = 1'b0;
        cur_st    = S_RUN;
        chk("start_state", DW'(Chk_State), DW'(S_RUN));
    endtask

    // Applies one sample vector; the bench's model pops only in RUN and only
    // when it knows the reference FIFO holds a word.
    task automatic run_vec(input int i);
        for (int c = 0; c < NC; c++) begin
            Dut_Dat[c*DW +: DW] = mkw(c, rd_k[c]) ^ (tbl[i].flip[c] ? bit7 : '0);
            if (cur_st == S_RUN && tbl[i].val[c] && rd_k[c] < wr_k[c]) rd_k[c]++;
        end
        Dut_Val = tbl[i].val;
        step();
        Dut_Val = '0;
        chk($sformatf("v%0d_cmp", i), DW'(Chk_CntCmp), DW'(tbl[i].cmp));
        chk($sformatf("v%0d_err", i), DW'(Chk_CntErr), DW'(tbl[i].err));
        chk($sformatf("v%0d_st", i),  DW'(Chk_State),  DW'(tbl[i].st));
        cur_st = tbl[i].st;
    endtask

    initial begin
        bit7 = '0;
        bit7[7] = 1'b1;
        // Case 1: matching stream over mixed valid patterns, ends in DONE
        tbl[0]  = '{4'h1, 4'h0, 1, 0, S_RUN};
        tbl[1]  = '{4'h2, 4'h0, 2, 0, S_RUN};
        tbl[2]  = '{4'h4, 4'h0, 3, 0, S_RUN};
        tbl[3]  = '{4'h8, 4'h0, 4, 0, S_RUN};
        tbl[4]  = '{4'hF, 4'h0, 8, 0, S_RUN};
        tbl[5]  = '{4'h3, 4'h0, 10, 0, S_RUN};
        tbl[6]  = '{4'hC, 4'h0, 12, 0, S_DONE};
        tbl[7]  = '{4'hF, 4'h0, 12, 0, S_DONE};
        // Case 2: ch2 sample 5 mismatches in bit 7, no stop
        tbl[8]  = '{4'h4, 4'h0, 1, 0, S_RUN};
        tbl[9]  = '{4'h4, 4'h0, 2, 0, S_RUN};
        tbl[10] = '{4'h4, 4'h0, 3, 0, S_RUN};
        tbl[11] = '{4'h4, 4'h0, 4, 0, S_RUN};
        tbl[12] = '{4'h4, 4'h0, 5, 0, S_RUN};
        tbl[13] = '{4'h4, 4'h4, 6, 1, S_RUN};
        // Case 3: same mismatch masked out
        tbl[14] = '{4'h4, 4'h4, 1, 0, S_RUN};
        // Case 4: underflow on ch1 with stop, then frozen
        tbl[15] = '{4'h2, 4'h0, 1, 1, S_HALT};
        tbl[16] = '{4'hF, 4'h0, 1, 1, S_HALT};
        // Case 6a: ch3 and ch0 mismatch together
        tbl[17] = '{4'h9, 4'h9, 2, 2, S_RUN};

        rst_n = 1'b0;
        Cfg_Start = 1'b0; Cfg_Flush = 1'b0; Cfg_StopOnErr = 1'b0;
        Cfg_Len = '0; Cfg_Mask = '1;
        Ref_Val = 1'b0; Ref_Ch = '0; Ref_Dat = '0;
        Dut_Val = '0; Dut_Dat = '0;
        s_start = 1'b0; s_len = '0; s_mask = '1; s_ref_val = 1'b0; s_ref_ch = '0;
        s_ref_dat = '0; s_dut_val = '0; s_dut_dat = '0;
        cur_st = S_IDLE;
        for (int c = 0; c < NC; c++) begin
            wr_k[c] = 0;
            rd_k[c] = 0;
        end

        // Reset values
        repeat (3) step();
        chk("rst_rdy",   DW'(Ref_Rdy),    DW'(0));
        chk("rst_state", DW'(Chk_State),  DW'(S_IDLE));
        chk("rst_cmp",   DW'(Chk_CntCmp), DW'(0));
        chk("rst_errv",  DW'(Chk_ErrVld), DW'(0));
        chk("rst_edat",  Chk_ErrDat,      '0);
        rst_n = 1'b1;
        step();
        chk("rel_rdy",   DW'(Ref_Rdy),    DW'(1));

        // Case 1
        for (int c = 0; c < NC; c++) for (int k = 0; k < 3; k++) push(c);
        start(12, 1'b0);
        for (int i = 0; i <= 7; i++) run_vec(i);
        chk("c1_errvld", DW'(Chk_ErrVld), DW'(0));

        // Case 2
        flush();
        for (int k = 0; k < 6; k++) push(2);
        start(0, 1'b0);
        for (int i = 8; i <= 13; i++) run_vec(i);
        chk("c2_errvld", DW'(Chk_ErrVld), DW'(1));
        chk("c2_errund", DW'(Chk_ErrUnd), DW'(0));
        chk("c2_errch",  DW'(Chk_ErrCh),  DW'(2));
        chk("c2_erridx", DW'(Chk_ErrIdx), DW'(5));
        chk("c2_errdat", Chk_ErrDat,      mkw(2, 5) ^ bit7);

        // Case 3
        push(2);
        start(0, 1'b0);
        Cfg_Mask = ~bit7;
        run_vec(14);
        Cfg_Mask = '1;
        chk("c3_errvld", DW'(Chk_ErrVld), DW'(0));

        // Case 4
        flush();
        start(0, 1'b1);
        run_vec(15);
        run_vec(16);
        chk("c4_errund", DW'(Chk_ErrUnd), DW'(1));
        chk("c4_errch",  DW'(Chk_ErrCh),  DW'(1));
        chk("c4_erridx", DW'(Chk_ErrIdx), DW'(0));

        // Case 6a
        flush();
        push(0);
        push(3);
        start(0, 1'b0);
        run_vec(17);
        chk("c6_errch",  DW'(Chk_ErrCh),  DW'(0));
        chk("c6_errund", DW'(Chk_ErrUnd), DW'(0));
        chk("c6_errdat", Chk_ErrDat,      mkw(0, 0) ^ bit7);

        // Case 5: fill ch0, push+pop at full, then drain to prove occupancy
        flush();
        for (int k = 0; k < RD; k++) push(0);
        Ref_Ch = 2'd0;
        #1 chk("c5_rdy_ch0_full", DW'(Ref_Rdy), DW'(0));
        Ref_Ch = 2'd1;
        #1 chk("c5_rdy_ch1",      DW'(Ref_Rdy), DW'(1));
        Ref_Val = 1'b1; Ref_Ch = 2'd0; Ref_Dat = mkw(0, 99);
        Dut_Dat[0 +: DW] = mkw(0, rd_k[0]);
        rd_k[0]++;
        Dut_Val = 4'h1;
        step();
        Ref_Val = 1'b0; Dut_Val = '0;
        chk("c5_pp_cmp", DW'(Chk_CntCmp), DW'(3));
        chk("c5_pp_rdy", DW'(Ref_Rdy),    DW'(1));
        push(0);
        chk("c5_refull", DW'(Ref_Rdy),    DW'(0));
        for (int k = 0; k < RD; k++) begin
            Dut_Dat[0 +: DW] = mkw(0, rd_k[0]);
            rd_k[0]++;
            Dut_Val = 4'h1;
            step();
        end
        Dut_Val = '0;
        chk("c5_drain_cmp", DW'(Chk_CntCmp), DW'(19));
        chk("c5_drain_err", DW'(Chk_CntErr), DW'(2));
        Dut_Val = 4'h1;
        step();
        Dut_Val = '0;
        chk("c5_under_err", DW'(Chk_CntErr), DW'(3));

        // Reset while running
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_state", DW'(Chk_State),  DW'(S_IDLE));
        chk("mid_rst_cmp",   DW'(Chk_CntCmp), DW'(0));

        // Case 6b: 4-bit counters saturate at 15 after 20 compares
        step();
        for (int c = 0; c < NC; c++) begin
            for (int k = 0; k < 5; k++) begin
                s_ref_val = 1'b1;
                s_ref_ch  = 2'(c);
                s_ref_dat = 8'(c * 16 + k);
                step();
            end
        end
        s_ref_val = 1'b0;
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        for (int t = 1; t <= 5; t++) begin
            for (int c = 0; c < NC; c++) s_dut_dat[c*8 +: 8] = 8'(c * 16 + t - 1);
            s_dut_val = 4'hF;
            step();
            s_dut_val = '0;
            chk($sformatf("sat_cmp_%0d", t), DW'(s_cmp), DW'((4 * t > 15) ? 15 : 4 * t));
        end
        chk("sat_err",   DW'(s_err),   DW'(0));
        chk("sat_state", DW'(s_state), DW'(S_RUN));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
